sysid_check_sequencer: RTL and testbench

Avalon-MM read master that sequences the system-ID slave after reset or on request. Reads word 0 (system ID) and word 1 (build timestamp), compares both against expected values and reports pass/fail. Sits beside the Qsys system-ID slave and gates bring-up logic, such as the camera/VIP start enable, on a matching hardware build. Handles slave wait states, timeout and bounded retry.

---
 rtl/sysid_check_sequencer.sv | 160 ++++++++++++++++
 tb/tb_sysid_check_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_sequencer.sv
// Avalon-MM read master that fetches the system-ID and build timestamp
// words after reset or on request and reports whether both match.
module sysid_check_sequencer #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457589968,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    GAP,
    DONE
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] wait_q;
  logic [15:0] wait_d;
  logic [3:0]  retry_q;
  logic [3:0]  retry_d;
  logic        auto_q;
  logic        auto_d;
  logic        pass_d;
  logic        id_match_d;
  logic        ts_match_d;
  logic        timeout_err_d;
  logic [31:0] id_value_d;
  logic [31:0] ts_value_d;
  logic        launch;
  logic        expired;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    retry_d       = retry_q;
    auto_d        = auto_q;
    pass_d        = pass;
    id_match_d    = id_match;
    ts_match_d    = ts_match;
    timeout_err_d = timeout_err;
    id_value_d    = id_value;
    ts_value_d    = ts_value;
    launch        = 1'b0;
    expired       = 1'b0;

    unique case (state_q)
      IDLE: launch = start | auto_q;
      DONE: launch = start;
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          wait_d = '0;
          if (state_q == RD_ID) begin
            id_value_d = avm_readdata;
            state_d    = RD_TS;
          end else begin
            ts_value_d = avm_readdata;
            state_d    = CMP;
          end
        end else if (wait_q == WAIT_LAST) begin
          expired = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      CMP: begin
        id_match_d = (id_value == EXPECTED_ID);
        ts_match_d = (ts_value == EXPECTED_TS);
        pass_d     = (id_value == EXPECTED_ID)
                   & (ts_value == EXPECTED_TS);
        state_d    = DONE;
      end
      GAP:     state_d = RD_ID;
      default: state_d = IDLE;
    endcase

    // A stalled read drops avm_read for one cycle (GAP or DONE)
    if (expired) begin
      wait_d = '0;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = GAP;
      end else begin
        timeout_err_d = 1'b1;
        state_d       = DONE;
      end
    end

    if (launch) begin
      auto_d        = 1'b0;
      pass_d        = 1'b0;
      id_match_d    = 1'b0;
      ts_match_d    = 1'b0;
      timeout_err_d = 1'b0;
      retry_d       = '0;
      wait_d        = '0;
      state_d       = RD_ID;
    end
  end

  // Bus and status outputs are flops decoded from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      retry_q     <= '0;
      auto_q      <= AUTO_START;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      auto_q      <= auto_d;
      avm_read    <= (state_d == RD_ID) | (state_d == RD_TS);
      avm_address <= (state_d == RD_TS);
      busy        <= (state_d == RD_ID) | (state_d == RD_TS)
                   | (state_d == CMP) | (state_d == GAP);
      done        <= (state_d == DONE);
      pass        <= pass_d;
      id_match    <= id_match_d;
      ts_match    <= ts_match_d;
      timeout_err <= timeout_err_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Bench for sysid_check_sequencer: cycle model compare plus directed
// checks for latency, stalls, timeout/retry, restart and async reset.
module tb_sysid_check_sequencer;

  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1457589968;
  localparam int TO = 8;
  localparam int MR = 2;

  localparam int P_IDLE = 0;
  localparam int P_READ = 1;
  localparam int P_CMP  = 2;
  localparam int P_DONE = 3;
  localparam int P_GAP  = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        id_match;
  logic        ts_match;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic        start0 = 1'b0;
  logic        wr0 = 1'b0;
  logic        addr0;
  logic        read0;
  logic [31:0] rdata0;
  logic        busy0;
  logic        done0;
  logic        pass0;
  logic        idm0;
  logic        tsm0;
  logic        to0;
  logic [31:0] idv0;
  logic [31:0] tsv0;

  int errors = 0;
  int checks = 0;
  int rd_cycles = 0;
  int rd0_cycles = 0;
  int n;

  logic [31:0] slave_id = EID;
  logic [31:0] slave_ts = ETS;
  int          id_stall = 0;
  bit          stuck = 1'b0;

  always #5 clock = ~clock;

  sysid_check_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR),
    .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .busy(busy),
    .done(done),
    .pass(pass),
    .id_match(id_match),
    .ts_match(ts_match),
    .timeout_err(timeout_err),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  assign rdata0 = addr0 ? ETS : EID;

  sysid_check_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR),
    .AUTO_START(1'b0)
  ) u_dut0 (
    .clock(clock),
    .reset_n(reset_n),
    .start(start0),
    .avm_address(addr0),
    .avm_read(read0),
    .avm_waitrequest(wr0),
    .avm_readdata(rdata0),
    .busy(busy0),
    .done(done0),
    .pass(pass0),
    .id_match(idm0),
    .ts_match(tsm0),
    .timeout_err(to0),
    .id_value(idv0),
    .ts_value(tsv0)
  );

  // Slave: responds mid-cycle to the registered address/read
  always @(posedge clock) begin
    #2;
    avm_waitrequest = stuck
      || (avm_read && !avm_address && id_stall > 0);
    if (avm_waitrequest && !stuck) id_stall--;
    avm_readdata = avm_address ? slave_ts : slave_id;
  end

  // Transaction-level model: which word is being read, how many
  // stalls seen, how many attempts made, what was captured.
  int          m_phase;
  int          m_word;
  int          m_waits;
  int          m_tries;
  bit          m_auto;
  logic [31:0] got [2];
  logic        m_idm;
  logic        m_tsm;
  logic        m_pass;
  logic        m_to;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = P_IDLE;
      m_word  = 0;
      m_waits = 0;
      m_tries = 0;
      m_auto  = 1'b1;
      got[0]  = '0;
      got[1]  = '0;
      m_idm   = 1'b0;
      m_tsm   = 1'b0;
      m_pass  = 1'b0;
      m_to    = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start || (m_phase == P_IDLE && m_auto)) begin
            m_auto  = 1'b0;
            m_idm   = 1'b0;
            m_tsm   = 1'b0;
            m_pass  = 1'b0;
            m_to    = 1'b0;
            m_tries = 0;
            m_waits = 0;
            m_word  = 0;
            m_phase = P_READ;
          end
        end
        P_READ: begin
          if (!avm_waitrequest) begin
            got[m_word] = avm_readdata;
            m_waits = 0;
            if (m_word == 1) m_phase = P_CMP;
            else m_word = 1;
          end else begin
            m_waits++;
            if (m_waits == TO) begin
              m_waits = 0;
              if (m_tries < MR) begin
                m_tries++;
                m_phase = P_GAP;
              end else begin
                m_to = 1'b1;
                m_phase = P_DONE;
              end
            end
          end
        end
        P_GAP: begin
          m_word  = 0;
          m_phase = P_READ;
        end
        default: begin
          m_idm   = (got[0] == EID);
          m_tsm   = (got[1] == ETS);
          m_pass  = m_idm && m_tsm;
          m_phase = P_DONE;
        end
      endcase
    end
  end

  logic [71:0] exp_vec;
  logic [71:0] act_vec;

  always @(negedge clock) begin
    exp_vec = {m_phase == P_READ && m_word == 1,
               m_phase == P_READ,
               m_phase == P_READ || m_phase == P_CMP
                 || m_phase == P_GAP,
               m_phase == P_DONE,
               m_pass, m_idm, m_tsm, m_to, got[0], got[1]};
    act_vec = {avm_address, avm_read, busy, done, pass,
               id_match, ts_match, timeout_err, id_value, ts_value};
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("FAIL cycle_model t=%0t: got %h expected %h",
               $time, act_vec, exp_vec);
    end
    if (avm_read) rd_cycles++;
    if (read0) rd0_cycles++;
  end

  task automatic check(input string name,
                       input logic [71:0] act,
                       input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input bit which, output int cnt);
    cnt = 0;
    do begin
      @(posedge clock);
      #1;
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        start0 = 1'b0;
      end
    end while (!(which ? done0 : done) && cnt < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {avm_read, busy, done, pass,
          id_value, ts_value}, 72'd0);
    rd_cycles = 0;
    reset_n = 1'b1;

    // 1: auto-start with a zero-wait slave
    wait_done(1'b0, n);
    check("t1_latency", 72'(n), 72'd4);
    check("t1_pass", 72'(pass), 72'd1);
    check("t1_id_value", 72'(id_value), 72'd0);
    check("t1_ts_value", 72'(ts_value), 72'd1457589968);
    check("t1_reads", 72'(rd_cycles), 72'd2);

    // 2: timestamp off by one
    slave_ts = ETS + 32'd1;
    start = 1'b1;
    wait_done(1'b0, n);
    check("t2_latency", 72'(n), 72'd4);
    check("t2_flags", {id_match, ts_match, pass, timeout_err},
          72'b1000);
    check("t2_ts_value", 72'(ts_value), 72'd1457589969);

    // 3: three wait states on the ID read
    slave_ts = ETS;
    id_stall = 3;
    rd_cycles = 0;
    start = 1'b1;
    wait_done(1'b0, n);
    check("t3_latency", 72'(n), 72'd7);
    check("t3_reads", 72'(rd_cycles), 72'd5);
    check("t3_pass", 72'(pass), 72'd1);

    // 4: slave never responds
    stuck = 1'b1;
    rd_cycles = 0;
    start = 1'b1;
    wait_done(1'b0, n);
    check("t4_latency", 72'(n), 72'd27);
    check("t4_reads", 72'(rd_cycles), 72'd24);
    check("t4_flags", {timeout_err, pass, busy, done}, 72'b1001);
    stuck = 1'b0;
    @(posedge clock);
    #1;

    // 5: start during RD_TS ignored, start in DONE reruns
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1;
    check("t5_in_rd_ts", {avm_read, avm_address}, 72'b11);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1;
    check("t5_done", {done, pass, busy, timeout_err}, 72'b1100);
    repeat (2) @(posedge clock);
    #1;
    check("t5_not_queued", {done, busy}, 72'b10);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check("t5_restart_clear", {done, busy, pass}, 72'b010);
    wait_done(1'b0, n);
    check("t5_rerun", {72'(n), done, pass}, {72'd3, 2'b11});

    // 6: reset while the second block stalls in RD_ID
    start0 = 1'b1;
    wr0 = 1'b1;
    @(posedge clock);
    #1 start0 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("t6_rd_id_held", {read0, addr0, busy0}, 72'b101);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_dut0", {addr0, read0, busy0, done0, pass0,
          idm0, tsm0, to0, idv0, tsv0}, 72'd0);
    check("t6_async_main", {avm_read, busy, done, pass,
          id_value, ts_value}, 72'd0);
    repeat (2) @(posedge clock);
    #1;
    wr0 = 1'b0;
    rd0_cycles = 0;
    start = 1'b1;
    reset_n = 1'b1;
    wait_done(1'b0, n);
    check("t6_coincident_start", 72'(n), 72'd4);
    repeat (4) @(posedge clock);
    #1;
    check("t6_single_run", {done, busy}, 72'b10);
    check("t6_dut0_idle", {72'(rd0_cycles), busy0, done0},
          {72'd0, 2'b00});
    start0 = 1'b1;
    wait_done(1'b1, n);
    check("t6_dut0_latency", 72'(n), 72'd4);
    check("t6_dut0_result", {pass0, to0, tsv0}, {2'b10, ETS});

    @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
